// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the ALU request record.
// Contents: opcode values for OP / OP-IMM, the ALU funct3 selects,
// the two legal funct7 encodings, and alu_req_t {r1, r2, funct3, funct7, rd}.
package riscv_pkg;

   localparam int unsigned RV_XLEN = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SL   = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [RV_XLEN-1:0] r1;
      logic [RV_XLEN-1:0] r2;
      logic [2:0]         funct3;
      logic               funct7;
      logic [4:0]         rd;
   } alu_req_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear, x0 hardwired to zero.
// Ports: clk, rst_n; raddr1/rdata1, raddr2/rdata2 (read); we/waddr/wdata (write).
module reg_file #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      raddr1,
   output logic [XLEN-1:0] rdata1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata2,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] mem_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == 5'd0) ? '0 : mem_q[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? '0 : mem_q[raddr2];

endmodule

// File: rtl/alu_issue.sv
// Decode / operand-issue stage in front of the ALU.
// Accepts RV32I words (instr_valid/instr_ready), decodes OP and OP-IMM,
// reads the register file and holds a registered request (issue_valid/
// issue_ready) carrying r1, r2, funct3, funct7, rd until accepted.
// wb_en/wb_rd/wb_data is the ALU writeback port; illegal pulses for one cycle
// when an unsupported instruction is consumed.
module alu_issue
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instr,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            issue_valid,
   input  logic            issue_ready,
   output logic [XLEN-1:0] r1,
   output logic [XLEN-1:0] r2,
   output logic [2:0]      funct3,
   output logic            funct7,
   output logic [4:0]      rd,
   output logic            illegal
);

   logic [6:0] opcode, f7;
   logic [2:0] f3;
   logic [4:0] rs1, rs2;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign f7     = instr[31:25];

   logic            dec_legal, dec_use_rs2, dec_funct7;
   logic [XLEN-1:0] dec_imm;

   always_comb begin
      dec_legal   = 1'b0;
      dec_use_rs2 = 1'b0;
      dec_funct7  = 1'b0;
      dec_imm     = '0;
      case (opcode)
         OPC_OP: begin
            dec_use_rs2 = 1'b1;
            dec_funct7  = instr[30];
            dec_legal   = (f7 == F7_BASE) ||
                          ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
         end
         OPC_OP_IMM: begin
            case (f3)
               F3_SL: begin
                  dec_imm   = {{(XLEN-5){1'b0}}, instr[24:20]};
                  dec_legal = (f7 == F7_BASE);
               end
               F3_SR: begin
                  dec_imm    = {{(XLEN-5){1'b0}}, instr[24:20]};
                  dec_funct7 = instr[30];
                  dec_legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
               end
               // ADDI and friends: funct7 stays 0 so an immediate add never subtracts
               default: begin
                  dec_imm   = {{(XLEN-12){instr[31]}}, instr[31:20]};
                  dec_legal = 1'b1;
               end
            endcase
         end
         default: ;
      endcase
   end

   logic [XLEN-1:0] rf_rd1, rf_rd2, op1, op2_reg;

   reg_file #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_reg_file (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr1 (rs1),
      .rdata1 (rf_rd1),
      .raddr2 (rs2),
      .rdata2 (rf_rd2),
      .we     (wb_en),
      .waddr  (wb_rd),
      .wdata  (wb_data)
   );

   // Forward a writeback landing on the same edge as the accept
   assign op1     = ((BYPASS != 0) && wb_en && (wb_rd == rs1) && (rs1 != 5'd0)) ?
                    wb_data : rf_rd1;
   assign op2_reg = ((BYPASS != 0) && wb_en && (wb_rd == rs2) && (rs2 != 5'd0)) ?
                    wb_data : rf_rd2;

   alu_req_t   req_q, req_d;
   logic       valid_q, valid_d, illegal_q, illegal_d;
   logic [4:0] rs1_q, rs1_d, rs2_q, rs2_d;
   logic       use_rs2_q, use_rs2_d;
   logic       accept, hold;

   assign instr_ready = !valid_q || issue_ready;
   assign accept      = instr_valid && instr_ready;
   assign hold        = valid_q && !issue_ready;

   always_comb begin
      req_d     = req_q;
      valid_d   = valid_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      use_rs2_d = use_rs2_q;
      illegal_d = accept && !dec_legal;
      if (accept && dec_legal) begin
         valid_d       = 1'b1;
         req_d.r1      = op1;
         req_d.r2      = dec_use_rs2 ? op2_reg : dec_imm;
         req_d.funct3  = f3;
         req_d.funct7  = dec_funct7;
         req_d.rd      = instr[11:7];
         rs1_d         = rs1;
         rs2_d         = rs2;
         use_rs2_d     = dec_use_rs2;
      end else begin
         if (issue_ready) valid_d = 1'b0;
         // Keep a stalled request's register operands current
         if (hold && wb_en) begin
            if ((wb_rd == rs1_q) && (rs1_q != 5'd0)) req_d.r1 = wb_data;
            if (use_rs2_q && (wb_rd == rs2_q) && (rs2_q != 5'd0)) req_d.r2 = wb_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q     <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         use_rs2_q <= 1'b0;
      end else begin
         req_q     <= req_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         use_rs2_q <= use_rs2_d;
      end
   end

   assign issue_valid = valid_q;
   assign illegal     = illegal_q;
   assign r1          = req_q.r1;
   assign r2          = req_q.r2;
   assign funct3      = req_q.funct3;
   assign funct7      = req_q.funct7;
   assign rd          = req_q.rd;

endmodule
